// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath width, canonical NOP, opcode values and the IF/ID record.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  // A bubble keeps the last PC fields; only valid and the instruction word change.
  function automatic ifid_t make_bubble(input ifid_t cur);
    ifid_t b;
    b       = cur;
    b.valid = 1'b0;
    b.instr = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, hold freezes, otherwise captures the fetch.
module if_id_reg
  import rv32_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q.valid <= 1'b0;
      r_q.instr <= NOP_INSTR;
      r_q.pc    <= '0;
      r_q.pc4   <= '0;
    end else if (flush_i) begin
      r_q <= make_bubble(r_q);
    end else if (!hold_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, next-PC selection, redirect flush counter and the IF/ID register.
module if_stage
  import rv32_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_ready_i,
  output logic            ifid_valid_o,
  output logic [31:0]     ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [15:0]     flush_cnt_o
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_tgt;
  logic [15:0]     r_flush_cnt;
  logic            w_fetch;
  logic            w_flush;
  ifid_t           w_ifid_d;
  ifid_t           w_ifid_q;

  assign w_pc_plus4     = r_pc + XLEN'(4);
  assign w_redirect_tgt = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
  assign w_fetch        = !redirect_i && !stall_i && imem_ready_i;
  // Redirect beats stall; an imem miss only bubbles when the stage is not stalled.
  assign w_flush        = redirect_i || (!stall_i && !imem_ready_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= w_redirect_tgt;
    end else if (w_fetch) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (redirect_i && (r_flush_cnt != 16'hFFFF)) begin
      r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  always_comb begin
    w_ifid_d.valid = 1'b1;
    w_ifid_d.instr = imem_rdata_i;
    w_ifid_d.pc    = r_pc;
    w_ifid_d.pc4   = w_pc_plus4;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .hold_i  (stall_i),
    .flush_i (w_flush),
    .d_i     (w_ifid_d),
    .q_o     (w_ifid_q)
  );

  assign imem_addr_o  = r_pc;
  assign ifid_valid_o = w_ifid_q.valid;
  assign ifid_instr_o = w_ifid_q.instr;
  assign ifid_pc_o    = w_ifid_q.pc;
  assign ifid_pc4_o   = w_ifid_q.pc4;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed and random checks of if_stage against a cycle-level behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall_i, redirect_i, imem_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic [31:0] imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o;
  logic        ifid_valid_o;
  logic [15:0] flush_cnt_o;

  logic        w_reset, w_stall, w_redirect, w_ready;
  logic [31:0] w_rpc, w_rdata;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic        w_valid;
  logic [15:0] w_fcnt;

  int n_err = 0;
  int n_chk = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid;
  logic [15:0] m_fcnt;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_ready_i(imem_ready_i),
    .ifid_valid_o(ifid_valid_o), .ifid_instr_o(ifid_instr_o),
    .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o), .flush_cnt_o(flush_cnt_o)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(w_reset), .stall_i(w_stall), .redirect_i(w_redirect),
    .redirect_pc_i(w_rpc), .imem_addr_o(w_addr),
    .imem_rdata_i(w_rdata), .imem_ready_i(w_ready),
    .ifid_valid_o(w_valid), .ifid_instr_o(w_instr),
    .ifid_pc_o(w_pc), .ifid_pc4_o(w_pc4), .flush_cnt_o(w_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge of the main instance, straight from the priority rules.
  task automatic model_edge(input logic rst, input logic st, input logic rd,
                            input logic [31:0] rpc, input logic rdy, input logic [31:0] data);
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13; m_ipc = 0; m_ipc4 = 0; m_fcnt = 0;
    end else if (rd) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = 32'h13;
      if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 1;
    end else if (st) begin
      // everything frozen
    end else if (!rdy) begin
      m_valid = 1'b0;
      m_instr = 32'h13;
    end else begin
      m_instr = data;
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 4;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  imem_addr_o,           m_pc);
    chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
    chk({tag, ".instr"}, ifid_instr_o,          m_instr);
    chk({tag, ".pc"},    ifid_pc_o,             m_ipc);
    chk({tag, ".pc4"},   ifid_pc4_o,            m_ipc4);
    chk({tag, ".fcnt"},  {16'd0, flush_cnt_o},  {16'd0, m_fcnt});
  endtask

  // Drive inputs, take one edge, update the model, sample 1ns later and compare.
  task automatic cyc(input string tag, input logic rst, input logic st, input logic rd,
                     input logic [31:0] rpc, input logic rdy, input logic [31:0] data);
    reset = rst; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    imem_ready_i = rdy; imem_rdata_i = data;
    @(posedge clk);
    model_edge(rst, st, rd, rpc, rdy, data);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic rst, st, rd, rdy;
    logic [31:0] rpc, data;

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 0;
    imem_ready_i = 1'b0; imem_rdata_i = 0;
    w_reset = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_rpc = 0; w_ready = 1'b0; w_rdata = 0;
    m_pc = 0; m_valid = 0; m_instr = 32'h13; m_ipc = 0; m_ipc4 = 0; m_fcnt = 0;
    #2;

    // Reset state
    cyc("reset", 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("reset.nop_const", ifid_instr_o, 32'h0000_0013);

    // Three straight fetches
    cyc("fetch0", 0, 0, 0, 0, 1, 32'h0050_0093);
    cyc("fetch1", 0, 0, 0, 0, 1, 32'h0030_0113);
    chk("fetch1.instr_const", ifid_instr_o, 32'h0030_0113);
    chk("fetch1.addr_const", imem_addr_o, 32'h8);
    cyc("fetch2", 0, 0, 0, 0, 1, 32'h0020_81B3);
    chk("fetch2.pc_const", ifid_pc_o, 32'h8);
    chk("fetch2.addr_const", imem_addr_o, 32'hC);

    // Stall at pc 0x10 for 3 cycles with junk on imem, then release
    cyc("fetch3", 0, 0, 0, 0, 1, 32'h1111_1111);
    for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, 0, 1, $urandom);
    chk("stall.addr_const", imem_addr_o, 32'h10);
    cyc("release", 0, 0, 0, 0, 1, 32'h2222_2222);
    chk("release.pc_const", ifid_pc_o, 32'h10);
    cyc("after_release", 0, 0, 0, 0, 1, 32'h3333_3333);
    chk("after_release.pc_const", ifid_pc_o, 32'h14);

    // Redirect wins over stall; low address bits dropped
    cyc("redirect", 0, 1, 1, 32'h0000_0042, 1, 32'h4444_4444);
    chk("redirect.addr_const", imem_addr_o, 32'h40);
    chk("redirect.fcnt_const", {16'd0, flush_cnt_o}, 32'd1);

    // imem not ready for two cycles
    cyc("notready0", 0, 0, 0, 0, 0, 32'h5555_5555);
    cyc("notready1", 0, 0, 0, 0, 0, 32'h5555_5555);
    cyc("ready", 0, 0, 0, 0, 1, 32'h6666_6666);
    chk("ready.pc_const", ifid_pc_o, 32'h40);

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      st   = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 9) == 0);
      rdy  = ($urandom_range(0, 4) != 0);
      rpc  = $urandom;
      data = $urandom;
      cyc("rand", rst, st, rd, rpc, rdy, data);
    end

    // Reset mid-stream while stalled
    cyc("pre_rst", 0, 0, 1, 32'h0000_0100, 1, 32'h0);
    cyc("pre_rst2", 0, 0, 0, 0, 1, 32'h7777_7777);
    cyc("mid_reset", 1, 1, 0, 0, 1, 32'h8888_8888);
    chk("mid_reset.valid_const", {31'd0, ifid_valid_o}, 32'd0);
    chk("mid_reset.fcnt_const", {16'd0, flush_cnt_o}, 32'd0);

    // Wrap-around instance starting at 0xFFFF_FFFC
    w_reset = 1'b1;
    @(posedge clk); #1;
    chk("wrap.reset_addr", w_addr, 32'hFFFF_FFFC);
    w_reset = 1'b0; w_ready = 1'b1; w_rdata = 32'hAAAA_0013;
    @(posedge clk); #1;
    chk("wrap.pc0", w_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4_0", w_pc4, 32'h0);
    chk("wrap.addr0", w_addr, 32'h0);
    w_rdata = 32'hBBBB_0013;
    @(posedge clk); #1;
    chk("wrap.pc1", w_pc, 32'h0);
    chk("wrap.pc4_1", w_pc4, 32'h4);
    chk("wrap.instr1", w_instr, 32'hBBBB_0013);
    chk("wrap.valid1", {31'd0, w_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
